// File: rtl/aes_mon_pkg.sv
// Shared definitions for the AES activity monitor.
//   mon_state_e    : trigger FSM state (ARMED / FIRED)
//   EN_AND / EN_OR : how the qualifying enable channels are combined
//   MAX_LATENCY / MAX_NUM_CH : upper bounds for the elaboration-time checks
package aes_mon_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } mon_state_e;

  localparam int EN_AND = 0;
  localparam int EN_OR  = 1;

  localparam int MAX_LATENCY = 64;
  localparam int MAX_NUM_CH  = 8;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register that tracks requests through the aes_128
// pipeline.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset; discards every in-flight entry
//   d   : valid bit entering the pipe this cycle
//   q   : d delayed by exactly DEPTH cycles (registered)
module valid_delay_line #(
  parameter int DEPTH = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] pipe_d;
  logic [DEPTH-1:0] pipe_q;

  // Shift up by one and insert d at bit 0; the cast drops the oldest entry
  // and keeps the expression valid for DEPTH == 1.
  always_comb begin
    pipe_d = DEPTH'({pipe_q, d});
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of process ordering.
  // NOTE: this shift register is deliberately reset (unlike a data memory):
  // a stale entry would emit out_valid for a request that was discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/aes_activity_monitor.sv
// Activity monitor beside the aes_128 core: aligns a valid strobe with the
// ciphertext, counts qualified completed encryptions and raises a trigger at a
// programmable threshold.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : new state/key presented to aes_128 this cycle
//   ch_en      : qualifying enables, sampled together with out_valid
//   clr        : synchronous clear of counter and trigger (wins over a count)
//   out_valid  : ciphertext valid this cycle (in_valid delayed LATENCY cycles)
//   enc_count  : qualified completed encryptions, saturating
//   trigger    : threshold reached (sticky, or one-cycle pulse in PULSE_MODE)
//   fire_count : number of times the trigger fired, saturating at 255
module aes_activity_monitor
  import aes_mon_pkg::*;
#(
  parameter int              LATENCY    = 21,
  parameter int              NUM_CH     = 2,
  parameter int              CNT_W      = 32,
  parameter longint unsigned THRESHOLD  = 1000,
  parameter int              EN_MODE    = EN_AND,
  parameter int              PULSE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              clr,
  output logic              out_valid,
  output logic [CNT_W-1:0]  enc_count,
  output logic              trigger,
  output logic [7:0]        fire_count
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("aes_activity_monitor: LATENCY out of range");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("aes_activity_monitor: NUM_CH out of range");
  end
  if (EN_MODE != EN_AND && EN_MODE != EN_OR) begin : g_bad_en_mode
    $error("aes_activity_monitor: EN_MODE must be EN_AND or EN_OR");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("aes_activity_monitor: CNT_W out of range");
  end

  logic       valid_w;
  logic       ch_ok;
  logic       qual;
  logic       cnt_sat;
  logic       thr_hit;
  logic [63:0] cnt_inc_wide;

  mon_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [7:0]       fire_d, fire_q;

  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .d   (in_valid),
    .q   (valid_w)
  );

  assign ch_ok   = (EN_MODE == EN_OR) ? (|ch_en) : (&ch_en);
  assign qual    = valid_w & ch_ok;
  assign cnt_sat = &cnt_q;

  // Compare the incremented count in 64 bits so a THRESHOLD wider than the
  // counter simply never matches.
  assign cnt_inc_wide = 64'(cnt_q) + 64'd1;
  assign thr_hit      = (THRESHOLD != 64'd0) && (cnt_inc_wide == THRESHOLD);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = fire_q;
    if (clr) begin
      cnt_d   = '0;
      state_d = ARMED;
    end else if (state_q == FIRED && PULSE_MODE != 0) begin
      // Pulse cycle: re-arm and drop any qualified completion arriving now.
      cnt_d   = '0;
      state_d = ARMED;
    end else if (qual && !cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q == ARMED && thr_hit) begin
        state_d = FIRED;
        if (fire_q != 8'hFF) begin
          fire_d = fire_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

  assign out_valid  = valid_w;
  assign enc_count  = cnt_q;
  assign trigger    = (state_q == FIRED);
  assign fire_count = fire_q;

endmodule
